// File: rtl/frame_anim_sequencer.sv
// Per-frame animation state for the VGA renderer: frame counter, starfield LFSR, bouncing text Y.
// Optional FRAME_PAUSE_EN: pause=1 at a frame boundary freezes the animation state.
module frame_anim_sequencer #(
  parameter int unsigned TOP_Y       = 20,
  parameter int unsigned FLOOR_Y     = 200,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned REST_FRAMES = 120,
  parameter int unsigned VMAX        = 15,
  parameter int unsigned MAX_BOUNCES = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        pause,
  output logic        frame_tick,
  output logic [15:0] frame_cnt,
  output logic [15:0] star_lfsr,
  output logic [9:0]  text_y,
  output logic [1:0]  phase
);

  localparam logic [1:0] StHold = 2'd0;
  localparam logic [1:0] StFall = 2'd1;
  localparam logic [1:0] StRise = 2'd2;
  localparam logic [1:0] StRest = 2'd3;

  localparam logic [9:0] TopY       = 10'(TOP_Y);
  localparam logic [9:0] FloorY     = 10'(FLOOR_Y);
  localparam logic [5:0] VMax       = 6'(VMAX);
  localparam logic [7:0] HoldLast   = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] RestLast   = 8'(REST_FRAMES - 1);
  localparam logic [3:0] BounceLast = 4'(MAX_BOUNCES - 1);

  logic        r_vsync_q;
  logic        r_tick;
  logic [15:0] r_frame_cnt;
  logic [15:0] r_lfsr;
  logic [9:0]  r_text_y;
  logic [1:0]  r_phase;
  logic [5:0]  r_vel;
  logic [3:0]  r_bounces;
  logic [7:0]  r_dwell;

  logic        w_boundary;
  logic        w_advance;
  logic        w_lfsr_fb;
  logic [6:0]  w_vinc;
  logic [5:0]  w_vnew;
  logic [10:0] w_fall_sum;
  logic [10:0] w_rise_lim;
  logic [5:0]  w_vel_dec;

  logic [9:0]  w_text_y_d;
  logic [1:0]  w_phase_d;
  logic [5:0]  w_vel_d;
  logic [3:0]  w_bounces_d;
  logic [7:0]  w_dwell_d;

  // Boundary is the rising edge of active-low vsync (end of the sync pulse).
  assign w_boundary = vsync & ~r_vsync_q;

`ifdef FRAME_PAUSE_EN
  assign w_advance = w_boundary & ~pause;
`else
  logic w_unused_pause;
  assign w_unused_pause = pause;
  assign w_advance      = w_boundary;
`endif

  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_vinc     = {1'b0, r_vel} + 7'd1;
  assign w_vnew     = (w_vinc > {1'b0, VMax}) ? VMax : w_vinc[5:0];
  // 11-bit sums so the floor/top comparisons never see a 10-bit wrap.
  assign w_fall_sum = {1'b0, r_text_y} + {5'd0, w_vnew};
  assign w_rise_lim = {1'b0, TopY} + {5'd0, r_vel};
  assign w_vel_dec  = r_vel - 6'd1;

  always_comb begin
    w_text_y_d  = r_text_y;
    w_phase_d   = r_phase;
    w_vel_d     = r_vel;
    w_bounces_d = r_bounces;
    w_dwell_d   = r_dwell;
    unique case (r_phase)
      StHold: begin
        if (r_dwell == HoldLast) begin
          w_dwell_d = 8'd0;
          w_vel_d   = 6'd0;
          w_phase_d = StFall;
        end else begin
          w_dwell_d = r_dwell + 8'd1;
        end
      end
      StFall: begin
        if (w_fall_sum >= {1'b0, FloorY}) begin
          w_text_y_d  = FloorY;
          w_vel_d     = w_vnew >> 1;
          w_bounces_d = r_bounces + 4'd1;
          if ((w_vnew[5:1] == 5'd0) || (r_bounces == BounceLast)) begin
            w_phase_d = StRest;
          end else begin
            w_phase_d = StRise;
          end
        end else begin
          w_text_y_d = w_fall_sum[9:0];
          w_vel_d    = w_vnew;
        end
      end
      StRise: begin
        if ({1'b0, r_text_y} < w_rise_lim) begin
          w_text_y_d = TopY;
        end else begin
          w_text_y_d = r_text_y - {4'd0, r_vel};
        end
        w_vel_d = w_vel_dec;
        if (w_vel_dec == 6'd0) begin
          w_phase_d = StFall;
        end
      end
      StRest: begin
        if (r_dwell == RestLast) begin
          w_text_y_d  = TopY;
          w_vel_d     = 6'd0;
          w_bounces_d = 4'd0;
          w_dwell_d   = 8'd0;
          w_phase_d   = StHold;
        end else begin
          w_dwell_d = r_dwell + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vsync_q   <= 1'b1;
      r_tick      <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_lfsr      <= LFSR_SEED;
      r_text_y    <= TopY;
      r_phase     <= StHold;
      r_vel       <= 6'd0;
      r_bounces   <= 4'd0;
      r_dwell     <= 8'd0;
    end else begin
      r_vsync_q <= vsync;
      r_tick    <= w_boundary;
      r_lfsr    <= w_boundary ? LFSR_SEED : {r_lfsr[14:0], w_lfsr_fb};
      if (w_advance) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_text_y    <= w_text_y_d;
        r_phase     <= w_phase_d;
        r_vel       <= w_vel_d;
        r_bounces   <= w_bounces_d;
        r_dwell     <= w_dwell_d;
      end
    end
  end

  assign frame_tick = r_tick;
  assign frame_cnt  = r_frame_cnt;
  assign star_lfsr  = r_lfsr;
  assign text_y     = r_text_y;
  assign phase      = r_phase;

endmodule
